// File: rtl/pipelined_prefix_adder.sv
// Three-stage parallel-prefix add/sub: S1 group g/p, S2 prefix-tree group carries, S3 result; result 2 edges after accept.
// Valid/ready elastic pipeline holding up to 3 ops; each stage loads when its successor is empty or draining.
module pipelined_prefix_adder #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4,
  parameter int TAGW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  localparam int TREESIZE = WIDTH / GROUPSIZE;
  localparam int LEVELS   = $clog2(TREESIZE);

  logic                r1_vld, r2_vld, r3_vld;
  logic [WIDTH-1:0]    r1_g, r1_p, r2_g, r2_p;
  logic [TREESIZE-1:0] r1_gg, r1_gp, r2_gc;
  logic                r1_c0, r2_c0;
  logic [TAGW-1:0]     r1_tag, r2_tag, r3_tag;
  logic [WIDTH-1:0]    r3_sum;
  logic                r3_cout, r3_ovf, r3_zero;

  logic                w_s1_en, w_s2_en, w_s3_en, w_fire;
  logic [WIDTH-1:0]    w_bop, w_g, w_p;
  logic                w_c0;
  logic [TREESIZE-1:0] w_gg, w_gp;
  logic [TREESIZE-1:0] w_tg, w_tp, w_ng, w_np, w_gc;
  logic [TREESIZE-1:0] w_cin_grp;
  logic [WIDTH-1:0]    w_c, w_sum;
  logic                w_run, w_ovf, w_zero;

  assign w_s3_en  = !r3_vld || out_ready;
  assign w_s2_en  = !r2_vld || w_s3_en;
  assign w_s1_en  = !r1_vld || w_s2_en;
  assign in_ready = !rst && w_s1_en;
  assign w_fire   = in_valid && in_ready;

  // Subtract is a + ~b + ~borrow, so both ops share one carry network.
  assign w_bop = in_sub ? ~in_b : in_b;
  assign w_c0  = in_sub ? ~in_cin : in_cin;
  assign w_g   = in_a & w_bop;
  assign w_p   = in_a ^ w_bop;

  always_comb begin
    w_gg = '0;
    w_gp = '1;
    for (int k = 0; k < TREESIZE; k++) begin
      for (int j = 0; j < GROUPSIZE; j++) begin
        w_gg[k] = w_g[k*GROUPSIZE+j] | (w_p[k*GROUPSIZE+j] & w_gg[k]);
        w_gp[k] = w_gp[k] & w_p[k*GROUPSIZE+j];
      end
    end
  end

  // Kogge-Stone span doubling over group (G,P); carry-in folded in after the tree.
  always_comb begin
    w_tg = r1_gg;
    w_tp = r1_gp;
    w_ng = '0;
    w_np = '0;
    for (int l = 0; l < LEVELS; l++) begin
      w_ng = w_tg;
      w_np = w_tp;
      for (int i = (1 << l); i < TREESIZE; i++) begin
        w_ng[i] = w_tg[i] | (w_tp[i] & w_tg[i-(1<<l)]);
        w_np[i] = w_tp[i] & w_tp[i-(1<<l)];
      end
      w_tg = w_ng;
      w_tp = w_np;
    end
    w_gc = w_tg | (w_tp & {TREESIZE{r1_c0}});
  end

  assign w_cin_grp = {r2_gc[TREESIZE-2:0], r2_c0};

  always_comb begin
    w_c   = '0;
    w_run = 1'b0;
    for (int k = 0; k < TREESIZE; k++) begin
      w_run = w_cin_grp[k];
      for (int j = 0; j < GROUPSIZE; j++) begin
        w_c[k*GROUPSIZE+j] = w_run;
        w_run = r2_g[k*GROUPSIZE+j] | (r2_p[k*GROUPSIZE+j] & w_run);
      end
    end
  end

  // Operands share a sign exactly when p[msb]==0; that sign is then g[msb].
  assign w_sum  = r2_p ^ w_c;
  assign w_ovf  = !r2_p[WIDTH-1] && (w_sum[WIDTH-1] != r2_g[WIDTH-1]);
  assign w_zero = (w_sum == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r2_vld  <= 1'b0;
      r3_vld  <= 1'b0;
      r3_sum  <= '0;
      r3_cout <= 1'b0;
      r3_ovf  <= 1'b0;
      r3_zero <= 1'b0;
      r3_tag  <= '0;
    end else if (flush) begin
      r1_vld <= 1'b0;
      r2_vld <= 1'b0;
      r3_vld <= 1'b0;
    end else begin
      if (w_s1_en) r1_vld <= w_fire;
      if (w_s2_en) r2_vld <= r1_vld;
      if (w_s3_en) r3_vld <= r2_vld;
      if (w_s3_en && r2_vld) begin
        r3_sum  <= w_sum;
        r3_cout <= r2_gc[TREESIZE-1];
        r3_ovf  <= w_ovf;
        r3_zero <= w_zero;
        r3_tag  <= r2_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r1_g   <= w_g;
      r1_p   <= w_p;
      r1_gg  <= w_gg;
      r1_gp  <= w_gp;
      r1_c0  <= w_c0;
      r1_tag <= in_tag;
    end
    if (w_s2_en && r1_vld) begin
      r2_g   <= r1_g;
      r2_p   <= r1_p;
      r2_gc  <= w_gc;
      r2_c0  <= r1_c0;
      r2_tag <= r1_tag;
    end
  end

  assign out_valid = r3_vld;
  assign out_sum   = r3_sum;
  assign out_cout  = r3_cout;
  assign out_ovf   = r3_ovf;
  assign out_zero  = r3_zero;
  assign out_tag   = r3_tag;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: three parameterisations driven in lockstep against an arithmetic reference.
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_cin, in_sub, out_ready;
  logic [63:0] in_a, in_b;
  logic [3:0]  in_tag;

  logic        rdy32, ov32, cout32, ovf32, zero32;
  logic [31:0] sum32;
  logic [3:0]  tag32;
  logic        rdy64, ov64, cout64, ovf64, zero64;
  logic [63:0] sum64;
  logic [3:0]  tag64;
  logic        rdy16, ov16, cout16, ovf16, zero16;
  logic [15:0] sum16;
  logic [3:0]  tag16;

  pipelined_prefix_adder #(.WIDTH(32), .GROUPSIZE(4), .TAGW(4)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_sum(sum32), .out_cout(cout32),
    .out_ovf(ovf32), .out_zero(zero32), .out_tag(tag32));

  pipelined_prefix_adder #(.WIDTH(64), .GROUPSIZE(8), .TAGW(4)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_sum(sum64), .out_cout(cout64),
    .out_ovf(ovf64), .out_zero(zero64), .out_tag(tag64));

  pipelined_prefix_adder #(.WIDTH(16), .GROUPSIZE(2), .TAGW(4)) u_dut16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy16),
    .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(ov16), .out_ready(out_ready), .out_sum(sum16), .out_cout(cout16),
    .out_ovf(ovf16), .out_zero(zero16), .out_tag(tag16));

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [3:0]  tag;
  } op_t;

  op_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  n_fail = 0;

  // Returns {sum[63:0], cout, ovf, zero} for a w-bit adder using integer arithmetic.
  function automatic logic [66:0] ref_res(input op_t o, input int w);
    logic signed [67:0] ua, ub, sa, sb, ci, u, s, lim;
    logic [63:0] mask, sum;
    logic        cout, ovf;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ua   = {4'b0, o.a & mask};
    ub   = {4'b0, o.b & mask};
    ci   = {67'b0, o.cin};
    sa   = o.a[w-1] ? ua - (68'sd1 <<< w) : ua;
    sb   = o.b[w-1] ? ub - (68'sd1 <<< w) : ub;
    if (o.sub) begin
      u    = ua - ub - ci;
      s    = sa - sb - ci;
      cout = (u >= 0);
    end else begin
      u    = ua + ub + ci;
      s    = sa + sb + ci;
      cout = u[w];
    end
    lim = 68'sd1 <<< (w - 1);
    ovf = (s >= lim) || (s < -lim);
    sum = u[63:0] & mask;
    return {sum, cout, ovf, (sum == 64'd0)};
  endfunction

  task automatic check(input string name, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_result(input op_t e);
    check("res32", {32'b0, sum32, cout32, ovf32, zero32, tag32, ov32}, {ref_res(e, 32), e.tag, 1'b1});
    check("res64", {sum64, cout64, ovf64, zero64, tag64, ov64}, {ref_res(e, 64), e.tag, 1'b1});
    check("res16", {48'b0, sum16, cout16, ovf16, zero16, tag16, ov16}, {ref_res(e, 16), e.tag, 1'b1});
  endtask

  // One clock: sample handshakes at negedge, score any taken result, then update the model after the edge.
  task automatic cycle(output logic fired);
    op_t  cur;
    logic take, kill;
    @(negedge clk);
    cur.a   = in_a;
    cur.b   = in_b;
    cur.cin = in_cin;
    cur.sub = in_sub;
    cur.tag = in_tag;
    fired   = in_valid && rdy32;
    take    = ov32 && out_ready;
    kill    = rst || flush;
    if (take) begin
      check("out_expected", {71'b0, q.size() != 0}, 72'd1);
      if (q.size() != 0) check_result(q.pop_front());
    end
    @(posedge clk);
    #1;
    if (kill) q.delete();
    else if (fired) q.push_back(cur);
  endtask

  task automatic tick();
    logic f;
    cycle(f);
  endtask

  task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_tag   = tag;
    in_valid = 1'b1;
  endtask

  // Single op into an empty pipe: invisible after edges k and k+1, present after k+2.
  task automatic single(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub, input logic [3:0] tag,
                        input logic [66:0] exp);
    out_ready = 1'b1;
    set_op(a, b, cin, sub, tag);
    tick();
    in_valid = 1'b0;
    check({name, "_lat_k"}, {71'b0, ov32}, 72'd0);
    tick();
    check({name, "_lat_k1"}, {71'b0, ov32}, 72'd0);
    tick();
    check({name, "_k2"}, {32'b0, sum32, cout32, ovf32, zero32, tag32, ov32}, {exp, tag, 1'b1});
    tick();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12 && q.size() != 0; i++) tick();
    check({name, "_drained"}, {40'b0, q.size()}, 72'd0);
  endtask

  initial begin
    logic  f;
    op_t   o;

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    set_op(64'h1234, 64'h5678, 1'b0, 1'b0, 4'hA);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_in_ready", {71'b0, rdy32}, 72'd0);
      check("rst_outputs", {32'b0, ov32, sum32, cout32, ovf32, zero32, tag32}, 72'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_release_ready", {71'b0, rdy32}, 72'd1);

    single("add_wrap", 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h1, {32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
    single("add_ovf", 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 4'h2, {32'h0, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
    single("sub_neg", 64'h5, 64'h7, 1'b0, 1'b1, 4'h3, {32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});

    // Fill with consumer stalled, then release.
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      set_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'(t));
      cycle(f);
      check("stall_accept", {71'b0, f}, 72'd1);
    end
    check("stall_full_ready", {71'b0, rdy32}, 72'd0);
    set_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4'd4);
    for (int i = 0; i < 3; i++) begin
      cycle(f);
      check("stall_no_accept", {71'b0, f}, 72'd0);
      o = q[0];
      check("stall_hold", {32'b0, sum32, cout32, ovf32, zero32, tag32, ov32}, {ref_res(o, 32), 4'd1, 1'b1});
    end
    out_ready = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 8 && !f; i++) cycle(f);
    check("tag4_accepted", {71'b0, f}, 72'd1);
    in_valid = 1'b0;
    drain("stall");

    // Flush with two ops in flight and a third offered alongside.
    out_ready = 1'b0;
    set_op(64'h11, 64'h22, 1'b0, 1'b0, 4'd5);
    tick();
    set_op(64'h33, 64'h44, 1'b0, 1'b0, 4'd6);
    tick();
    set_op(64'h55, 64'h66, 1'b0, 1'b0, 4'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_out_valid", {71'b0, ov32}, 72'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_quiet", {71'b0, ov32}, 72'd0);
    end
    o = '{a: 64'hDEAD_BEEF, b: 64'h0123_4567, cin: 1'b1, sub: 1'b1, tag: 4'd8};
    single("post_flush", o.a, o.b, o.cin, o.sub, o.tag, ref_res(o, 32));

    // Random lockstep stream across all three widths.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 7))
        0:       in_a = {64{1'b1}};
        1:       in_a = 64'h0;
        2:       in_a = 64'h8000_8000_8000_8000;
        default: in_a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0:       in_b = {64{1'b1}};
        1:       in_b = 64'h0;
        2:       in_b = 64'h7FFF_7FFF_7FFF_7FFF;
        default: in_b = {$urandom, $urandom};
      endcase
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      in_tag    = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      rst       = (i == 400);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain("random");

    // Mid-stream reset, then first op keeps the two-edge latency.
    out_ready = 1'b0;
    set_op(64'h99, 64'h1, 1'b0, 1'b0, 4'd9);
    tick();
    tick();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", {71'b0, ov32}, 72'd0);
    o = '{a: 64'h8000_0000, b: 64'h1, cin: 1'b1, sub: 1'b1, tag: 4'd10};
    single("post_rst", o.a, o.b, o.cin, o.sub, o.tag, ref_res(o, 32));
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
